// File: rtl/sys_defs.sv
// Shared processor typedefs: physical-register tag, RS removal packet and the
// per-FU completion slot held by the CDB arbiter.
`ifndef RS_SZ
`define RS_SZ 16
`endif

package sys_defs;

   localparam int PHYS_REG_W = 6;
   localparam int RS_IDX_W   = $clog2(`RS_SZ);

   typedef struct packed {
      logic [PHYS_REG_W-1:0] phys_reg;
      logic                  ready;
      logic                  valid;
   } TAG;

   typedef struct packed {
      logic                remove_en;
      logic [RS_IDX_W-1:0] remove_idx;
   } EX_RS_PACKET;

   typedef struct packed {
      logic                valid;
      TAG                  tag;
      logic                has_dest;
      logic [RS_IDX_W-1:0] rs_idx;
   } CDB_SLOT;

endpackage

// File: rtl/cdb_rr_arb.sv
// One-hot arbiter: the first requester found searching upward from ptr wins.
// Fixed priority is simply ptr tied to zero by the parent (see CDB_RR_EN).
module cdb_rr_arb #(
   parameter int N     = 5,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant
);

   always_comb begin
      int   idx;
      logic found;
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one completion slot per FU, one broadcast per cycle.
// Define CDB_RR_EN for round-robin arbitration; default is fixed priority.
`ifndef RS_SZ
`define RS_SZ 16
`endif

module cdb_arbiter
   import sys_defs::*;
#(
   parameter int NUM_FU = 5,
   parameter int IDX_W  = $clog2(`RS_SZ)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         interrupt,
   input  logic [NUM_FU-1:0]            fu_done,
   input  TAG   [NUM_FU-1:0]            fu_tag,
   input  logic [NUM_FU-1:0]            fu_has_dest,
   input  logic [NUM_FU-1:0][IDX_W-1:0] fu_rs_idx,
   output logic [NUM_FU-1:0]            fu_ready,
   output TAG                           cdb,
   output logic                         cdb_en,
   output EX_RS_PACKET                  ex_rs_packet
);

   localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   CDB_SLOT            slot_reg [NUM_FU];
   logic [NUM_FU-1:0]  slot_valid;
   logic [NUM_FU-1:0]  grant;
   logic [NUM_FU-1:0]  capture;
   logic [PTR_W-1:0]   grant_idx;
   logic [PTR_W-1:0]   rr_ptr;
   logic               any_grant;

   // A granted slot frees up in the same edge, so its FU may refill it immediately.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_FU; gi++) begin : g_slot
         assign slot_valid[gi] = slot_reg[gi].valid;
         assign fu_ready[gi]   = !slot_reg[gi].valid || grant[gi];
         assign capture[gi]    = fu_done[gi] && fu_ready[gi] && !interrupt;
      end
   endgenerate

   cdb_rr_arb #(
      .N     (NUM_FU),
      .PTR_W (PTR_W)
   ) u_arb (
      .req   (slot_valid),
      .ptr   (rr_ptr),
      .grant (grant)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (grant[i]) grant_idx = PTR_W'(i);
      end
   end

   assign any_grant = |grant;

`ifdef CDB_RR_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (any_grant && !interrupt) begin
         rr_ptr <= (grant_idx == PTR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
      end
   end
`else
   assign rr_ptr = '0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_FU; i++) slot_reg[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) begin
            if (interrupt) begin
               slot_reg[i].valid <= 1'b0;
            end else if (capture[i]) begin
               slot_reg[i].valid    <= 1'b1;
               slot_reg[i].tag      <= fu_tag[i];
               slot_reg[i].has_dest <= fu_has_dest[i];
               slot_reg[i].rs_idx   <= RS_IDX_W'(fu_rs_idx[i]);
            end else if (grant[i]) begin
               slot_reg[i].valid <= 1'b0;
            end
         end
      end
   end

   // cdb and remove_idx keep their last value between broadcasts.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cdb          <= '0;
         cdb_en       <= 1'b0;
         ex_rs_packet <= '0;
      end else if (interrupt || !any_grant) begin
         cdb_en                 <= 1'b0;
         ex_rs_packet.remove_en <= 1'b0;
      end else begin
         ex_rs_packet.remove_en  <= 1'b1;
         ex_rs_packet.remove_idx <= slot_reg[grant_idx].rs_idx;
         cdb_en                  <= slot_reg[grant_idx].has_dest;
         if (slot_reg[grant_idx].has_dest) begin
            cdb.phys_reg <= slot_reg[grant_idx].tag.phys_reg;
            cdb.ready    <= 1'b1;
            cdb.valid    <= 1'b1;
         end
      end
   end

endmodule
